// File: rtl/reg_file_sv.sv
// rtl/reg_file_sv.sv - scalar + vector register file with conv write-back pending buffer
//
// Purpose:
//   Write-back end of the pipeline. Commits scalar writes, vector writes and
//   conv-engine results; serves two scalar and two vector combinational read
//   ports with same-cycle write-through bypass. A one-entry pending buffer
//   absorbs a conv result that arrives in the same cycle as a vector
//   write-back, since the vector array has a single write port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_write, rD, swrite_data scalar write-back
//   v_write, rD, vwrite_data vector write-back
//   conv_write, conv_addr,
//   conv_result, conv_ready  conv-engine write request / accept handshake
//   rs1/rs2 -> rs1/rs2_data  scalar read ports (S[0] reads as zero)
//   vs1/vs2 -> vs1/vs2_data  vector read ports
//   pend_valid               pending conv entry held (status)

module reg_file_sv #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int SW     = 32,
  parameter int LENGTH = 8,
  parameter int VW     = LENGTH * 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_write,
  input  logic          v_write,
  input  logic [AW-1:0] rD,
  input  logic [SW-1:0] swrite_data,
  input  logic [VW-1:0] vwrite_data,
  input  logic          conv_write,
  input  logic [AW-1:0] conv_addr,
  input  logic [VW-1:0] conv_result,
  output logic          conv_ready,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic [SW-1:0] rs1_data,
  output logic [SW-1:0] rs2_data,
  input  logic [AW-1:0] vs1,
  input  logic [AW-1:0] vs2,
  output logic [VW-1:0] vs1_data,
  output logic [VW-1:0] vs2_data,
  output logic          pend_valid
);

  logic [SW-1:0] s_q [NREG];
  logic [VW-1:0] v_q [NREG];

  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [VW-1:0] pend_data_q, pend_data_d;

  // Single vector-array write port, selected by the commit priority below.
  logic          v_we;
  logic [AW-1:0] v_waddr;
  logic [VW-1:0] v_wdata;

  logic conv_accept;

  assign conv_ready  = ~pend_valid_q & ~rst;
  assign conv_accept = conv_write & conv_ready;
  assign pend_valid  = pend_valid_q;

  always_comb begin
    v_we         = 1'b0;
    v_waddr      = rD;
    v_wdata      = vwrite_data;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (v_write) begin
      v_we = 1'b1;
      // Write-back is newer than any held conv result to the same register.
      if (pend_valid_q && (pend_addr_q == rD)) begin
        pend_valid_d = 1'b0;
      end
      // An accepted conv implies the buffer was empty, so loading never
      // clobbers a held entry. Same-address conv is dropped outright.
      if (conv_accept && (conv_addr != rD)) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = conv_addr;
        pend_data_d  = conv_result;
      end
    end else if (pend_valid_q) begin
      v_we         = 1'b1;
      v_waddr      = pend_addr_q;
      v_wdata      = pend_data_q;
      pend_valid_d = 1'b0;
    end else if (conv_accept) begin
      v_we    = 1'b1;
      v_waddr = conv_addr;
      v_wdata = conv_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        s_q[i] <= '0;
        v_q[i] <= '0;
      end
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      if (s_write && (rD != '0)) begin
        s_q[rD] <= swrite_data;
      end
      if (v_we) begin
        v_q[v_waddr] <= v_wdata;
      end
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Scalar reads: address 0 is forced to zero regardless of array contents.
  assign rs1_data = (rs1 == '0)                  ? '0          :
                    (s_write && (rD == rs1))     ? swrite_data : s_q[rs1];
  assign rs2_data = (rs2 == '0)                  ? '0          :
                    (s_write && (rD == rs2))     ? swrite_data : s_q[rs2];

  // Vector reads: bypass in the same order the values would land in the array.
  assign vs1_data = (v_write && (rD == vs1))               ? vwrite_data :
                    (pend_valid_q && (pend_addr_q == vs1)) ? pend_data_q :
                    (conv_accept && (conv_addr == vs1))    ? conv_result : v_q[vs1];
  assign vs2_data = (v_write && (rD == vs2))               ? vwrite_data :
                    (pend_valid_q && (pend_addr_q == vs2)) ? pend_data_q :
                    (conv_accept && (conv_addr == vs2))    ? conv_result : v_q[vs2];

endmodule

// File: tb/tb_reg_file_sv.sv
// tb/tb_reg_file_sv.sv - table-driven bench for reg_file_sv
module tb_reg_file_sv;

  localparam int SW = 32;
  localparam int VW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_write, v_write, conv_write;
  logic [4:0]    rD, conv_addr, rs1, rs2, vs1, vs2;
  logic [SW-1:0] swrite_data, rs1_data, rs2_data;
  logic [VW-1:0] vwrite_data, conv_result, vs1_data, vs2_data;
  logic          conv_ready, pend_valid;

  int total  = 0;
  int passed = 0;

  reg_file_sv #(.NREG(32), .AW(5), .SW(SW), .LENGTH(8), .VW(VW)) dut (
    .clk(clk), .rst(rst),
    .s_write(s_write), .v_write(v_write), .rD(rD),
    .swrite_data(swrite_data), .vwrite_data(vwrite_data),
    .conv_write(conv_write), .conv_addr(conv_addr), .conv_result(conv_result),
    .conv_ready(conv_ready),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .vs1(vs1), .vs2(vs2), .vs1_data(vs1_data), .vs2_data(vs2_data),
    .pend_valid(pend_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sw, vw;
    logic [4:0]    rd;
    logic [31:0]   sd;
    logic [63:0]   vd;
    logic          cw;
    logic [4:0]    ca;
    logic [63:0]   cr;
    logic [4:0]    r1, r2, v1, v2;
    logic [31:0]   e_r1, e_r2;
    logic [63:0]   e_v1, e_v2;
    logic          e_rdy, e_pv;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  function automatic vec_t row(
    input logic sw, input logic vw, input logic [4:0] rd, input logic [31:0] sd,
    input logic [63:0] vd, input logic cw, input logic [4:0] ca, input logic [63:0] cr,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] v1, input logic [4:0] v2,
    input logic [31:0] e_r1, input logic [31:0] e_r2, input logic [63:0] e_v1,
    input logic [63:0] e_v2, input logic e_rdy, input logic e_pv);
    vec_t v;
    v.sw = sw; v.vw = vw; v.rd = rd; v.sd = sd; v.vd = vd;
    v.cw = cw; v.ca = ca; v.cr = cr;
    v.r1 = r1; v.r2 = r2; v.v1 = v1; v.v2 = v2;
    v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_v1 = e_v1; v.e_v2 = e_v2;
    v.e_rdy = e_rdy; v.e_pv = e_pv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    s_write = 0; v_write = 0; conv_write = 0;
    rD = 0; conv_addr = 0; swrite_data = 0; vwrite_data = 0; conv_result = 0;
    rs1 = 0; rs2 = 0; vs1 = 0; vs2 = 0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i); vs1 = 5'(i); vs2 = 5'(31 - i);
      #1;
      chk({tag, "_rs1"}, 64'(rs1_data), 64'h0);
      chk({tag, "_rs2"}, 64'(rs2_data), 64'h0);
      chk({tag, "_vs1"}, vs1_data, 64'h0);
      chk({tag, "_vs2"}, vs2_data, 64'h0);
    end
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    tbl[0]  = row(1,0,5,DB,0,          0,0,0,          5,0,0,0,  DB,0,0,0,                 1,0);
    tbl[1]  = row(1,0,0,1,0,           0,0,0,          5,0,0,0,  DB,0,0,0,                 1,0);
    tbl[2]  = row(0,0,0,0,0,           0,0,0,          0,5,0,0,  0,DB,0,0,                 1,0);
    tbl[3]  = row(0,1,3,0,rep(8'hA3),  1,7,rep(8'hC7), 5,0,7,3,  DB,0,rep(8'hC7),rep(8'hA3),1,0);
    tbl[4]  = row(0,0,0,0,0,           1,8,rep(8'hC8), 5,0,7,8,  DB,0,rep(8'hC7),0,        0,1);
    tbl[5]  = row(0,0,0,0,0,           1,8,rep(8'hC8), 5,0,7,8,  DB,0,rep(8'hC7),rep(8'hC8),1,0);
    tbl[6]  = row(0,1,4,0,rep(8'hA4),  1,4,rep(8'hC4), 5,0,4,8,  DB,0,rep(8'hA4),rep(8'hC8),1,0);
    tbl[7]  = row(0,0,0,0,0,           0,0,0,          5,0,4,3,  DB,0,rep(8'hA4),rep(8'hA3),1,0);
    tbl[8]  = row(0,1,2,0,rep(8'hA2),  1,9,rep(8'hC9), 5,0,9,2,  DB,0,rep(8'hC9),rep(8'hA2),1,0);
    tbl[9]  = row(0,1,9,0,rep(8'hB9),  0,0,0,          5,0,9,2,  DB,0,rep(8'hB9),rep(8'hA2),0,1);
    tbl[10] = row(0,0,0,0,0,           0,0,0,          5,0,9,7,  DB,0,rep(8'hB9),rep(8'hC7),1,0);
    tbl[11] = row(0,0,0,0,0,           0,0,0,          5,0,9,4,  DB,0,rep(8'hB9),rep(8'hA4),1,0);
    tbl[12] = row(0,1,5,0,rep(8'hA5),  1,10,rep(8'hCA),5,0,10,5, DB,0,rep(8'hCA),rep(8'hA5),1,0);
    tbl[13] = row(0,1,2,0,rep(8'hB2),  0,0,0,          5,0,10,2, DB,0,rep(8'hCA),rep(8'hB2),0,1);
    tbl[14] = row(0,0,0,0,0,           0,0,0,          5,0,10,2, DB,0,rep(8'hCA),rep(8'hB2),0,1);
    tbl[15] = row(0,0,0,0,0,           0,0,0,          5,0,10,5, DB,0,rep(8'hCA),rep(8'hA5),1,0);

    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_conv_ready_low", 64'(conv_ready), 64'h0);
    chk("rst_pend_valid", 64'(pend_valid), 64'h0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_conv_ready", 64'(conv_ready), 64'h1);
    check_all_zero("reset");

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_write = tbl[i].sw; v_write = tbl[i].vw; rD = tbl[i].rd;
      swrite_data = tbl[i].sd; vwrite_data = tbl[i].vd;
      conv_write = tbl[i].cw; conv_addr = tbl[i].ca; conv_result = tbl[i].cr;
      rs1 = tbl[i].r1; rs2 = tbl[i].r2; vs1 = tbl[i].v1; vs2 = tbl[i].v2;
      #1;
      chk($sformatf("row%0d_rs1", i), 64'(rs1_data), 64'(tbl[i].e_r1));
      chk($sformatf("row%0d_rs2", i), 64'(rs2_data), 64'(tbl[i].e_r2));
      chk($sformatf("row%0d_vs1", i), vs1_data, tbl[i].e_v1);
      chk($sformatf("row%0d_vs2", i), vs2_data, tbl[i].e_v2);
      chk($sformatf("row%0d_rdy", i), 64'(conv_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("row%0d_pend", i), 64'(pend_valid), 64'(tbl[i].e_pv));
    end

    // Reset while a pending conv entry is held: the entry must be lost.
    @(negedge clk);
    idle_inputs();
    v_write = 1; rD = 1; vwrite_data = rep(8'hA1);
    conv_write = 1; conv_addr = 11; conv_result = rep(8'hCB);
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #1;
    chk("mid_rst_pend_held", 64'(pend_valid), 64'h1);
    chk("mid_rst_conv_ready", 64'(conv_ready), 64'h0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("after_mid_rst_pend", 64'(pend_valid), 64'h0);
    chk("after_mid_rst_ready", 64'(conv_ready), 64'h1);
    check_all_zero("mid_rst");
    @(negedge clk);
    vs1 = 11; vs2 = 1;
    #1;
    chk("pend_lost_v11", vs1_data, 64'h0);
    chk("pend_lost_v1", vs2_data, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
